// File: rtl/writeback_arbiter.sv
// Register-file write-back arbiter: execute pipeline vs. queued long-latency results,
// pipeline priority with a starvation guard. Optional decode bypass under `WB_FWD_EN.
module writeback_arbiter #(
  parameter int DATA_W       = 8,
  parameter int PTR_W        = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          reset_WB,
  input  logic                          pipe_valid,
  input  logic [PTR_W-1:0]              pipe_dst,
  input  logic [DATA_W-1:0]             pipe_data,
  output logic                          pipe_ready,
  input  logic                          ll_valid,
  input  logic [PTR_W-1:0]              ll_dst,
  input  logic [DATA_W-1:0]             ll_data,
  output logic                          ll_ready,
  output logic                          wb_we,
  output logic [PTR_W-1:0]              wb_dst,
  output logic [DATA_W-1:0]             wb_data,
  output logic [$clog2(FIFO_DEPTH):0]   ll_pending
`ifdef WB_FWD_EN
  ,
  input  logic [PTR_W-1:0]              fwd_src_0,
  input  logic [PTR_W-1:0]              fwd_src_1,
  input  logic [PTR_W-1:0]              fwd_src_2,
  output logic                          fwd_hit_0,
  output logic                          fwd_hit_1,
  output logic                          fwd_hit_2,
  output logic [DATA_W-1:0]             fwd_data_0,
  output logic [DATA_W-1:0]             fwd_data_1,
  output logic [DATA_W-1:0]             fwd_data_2
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [PTR_W-1:0]  r_mem_dst  [FIFO_DEPTH];
  logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [AW:0]       r_count;
  logic [CW-1:0]     r_starve;

  logic w_empty, w_full, w_starved, w_enq, w_pipe_gnt, w_fifo_gnt;

  // Grant uses registered occupancy, so a fresh entry is never granted in its enqueue cycle.
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_starved  = !w_empty && (r_starve == CW'(STARVE_LIMIT));
  assign w_enq      = ll_valid && !w_full;
  assign w_pipe_gnt = !w_starved && pipe_valid;
  assign w_fifo_gnt = !w_empty && (w_starved || !pipe_valid);

  assign pipe_ready = !w_starved;
  assign ll_ready   = !w_full;
  assign ll_pending = r_count;

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_dst[r_wptr]  <= ll_dst;
      r_mem_data[r_wptr] <= ll_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_WB) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      wb_we    <= 1'b0;
      wb_dst   <= '0;
      wb_data  <= '0;
    end else begin
      if (w_enq)      r_wptr <= r_wptr + 1'b1;
      if (w_fifo_gnt) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_enq) - (AW+1)'(w_fifo_gnt);

      if (w_empty || w_fifo_gnt)
        r_starve <= '0;
      else if (w_pipe_gnt && r_starve != CW'(STARVE_LIMIT))
        r_starve <= r_starve + 1'b1;

      // Idle cycles drop the strobe but keep the last dst/data on the bus.
      if (w_pipe_gnt) begin
        wb_we   <= 1'b1;
        wb_dst  <= pipe_dst;
        wb_data <= pipe_data;
      end else if (w_fifo_gnt) begin
        wb_we   <= 1'b1;
        wb_dst  <= r_mem_dst[r_rptr];
        wb_data <= r_mem_data[r_rptr];
      end else begin
        wb_we   <= 1'b0;
      end
    end
  end

`ifdef WB_FWD_EN
  assign fwd_hit_0  = wb_we && (wb_dst == fwd_src_0);
  assign fwd_hit_1  = wb_we && (wb_dst == fwd_src_1);
  assign fwd_hit_2  = wb_we && (wb_dst == fwd_src_2);
  assign fwd_data_0 = wb_data;
  assign fwd_data_1 = wb_data;
  assign fwd_data_2 = wb_data;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: a queue-based model predicts every RF write,
// a separate monitor pops and compares them as wb_we strobes appear.
module tb_writeback_arbiter;
  localparam int DW = 8, PW = 4, D = 4, SL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_WB = 1'b0;
  logic          pipe_valid = 1'b0, ll_valid = 1'b0;
  logic [PW-1:0] pipe_dst = '0, ll_dst = '0;
  logic [DW-1:0] pipe_data = '0, ll_data = '0;
  logic          pipe_ready, ll_ready, wb_we;
  logic [PW-1:0] wb_dst;
  logic [DW-1:0] wb_data;
  logic [$clog2(D):0] ll_pending;
`ifdef WB_FWD_EN
  logic [PW-1:0] fwd_src_0 = '0, fwd_src_1 = '0, fwd_src_2 = '0;
  logic          fwd_hit_0, fwd_hit_1, fwd_hit_2;
  logic [DW-1:0] fwd_data_0, fwd_data_1, fwd_data_2;
`endif

  writeback_arbiter #(.DATA_W(DW), .PTR_W(PW), .FIFO_DEPTH(D), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset_WB(reset_WB),
    .pipe_valid(pipe_valid), .pipe_dst(pipe_dst), .pipe_data(pipe_data), .pipe_ready(pipe_ready),
    .ll_valid(ll_valid), .ll_dst(ll_dst), .ll_data(ll_data), .ll_ready(ll_ready),
    .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data), .ll_pending(ll_pending)
`ifdef WB_FWD_EN
    , .fwd_src_0(fwd_src_0), .fwd_src_1(fwd_src_1), .fwd_src_2(fwd_src_2),
    .fwd_hit_0(fwd_hit_0), .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2),
    .fwd_data_0(fwd_data_0), .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2)
`endif
  );

  typedef struct { logic [PW-1:0] dst; logic [DW-1:0] data; int due; } wr_t;
  typedef struct { logic [PW-1:0] dst; logic [DW-1:0] data; } ent_t;

  wr_t  sb[$];
  ent_t mq[$];
  int   msc = 0;
  bit   mvalid = 0;
  bit   cur_we = 0;
  logic [PW-1:0] cur_dst = '0;
  logic [DW-1:0] cur_data = '0;
  int   cyc = 0;
  int   checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; the model predicts this cycle's outputs and the next write.
  task automatic step(input bit rst, input bit pv, input logic [PW-1:0] pd, input logic [DW-1:0] pdat,
                      input bit lv, input logic [PW-1:0] ld, input logic [DW-1:0] ldat);
    bit   starved, pre_empty, full;
    int   win;
    ent_t e;
    @(negedge clk);
    reset_WB = rst; pipe_valid = pv; pipe_dst = pd; pipe_data = pdat;
    ll_valid = lv; ll_dst = ld; ll_data = ldat;
`ifdef WB_FWD_EN
    fwd_src_0 = PW'($urandom); fwd_src_1 = cur_dst; fwd_src_2 = PW'($urandom);
`endif
    #1;
    if (mvalid) begin
      chk("ll_pending", ll_pending, mq.size());
      chk("ll_ready", ll_ready, (mq.size() != D) ? 1 : 0);
      chk("pipe_ready", pipe_ready, (mq.size() > 0 && msc == SL) ? 0 : 1);
      chk("wb_dst", wb_dst, cur_dst);
      chk("wb_data", wb_data, cur_data);
`ifdef WB_FWD_EN
      chk("fwd_hit_0", fwd_hit_0, (cur_we && cur_dst == fwd_src_0) ? 1 : 0);
      chk("fwd_hit_1", fwd_hit_1, cur_we ? 1 : 0);
      chk("fwd_hit_2", fwd_hit_2, (cur_we && cur_dst == fwd_src_2) ? 1 : 0);
      chk("fwd_data_1", fwd_data_1, cur_data);
`endif
    end
    if (rst) begin
      mq.delete();
      msc = 0; cur_we = 0; cur_dst = '0; cur_data = '0; mvalid = 1;
    end else if (mvalid) begin
      pre_empty = (mq.size() == 0);
      full      = (mq.size() == D);
      starved   = !pre_empty && msc == SL;
      win = starved ? 2 : pv ? 1 : !pre_empty ? 2 : 0;
      cur_we = (win != 0);
      if (win == 1) begin
        cur_dst = pd; cur_data = pdat;
      end else if (win == 2) begin
        e = mq.pop_front();
        cur_dst = e.dst; cur_data = e.data;
      end
      if (cur_we) sb.push_back('{cur_dst, cur_data, cyc + 1});
      if (lv && !full) mq.push_back('{ld, ldat});
      if (pre_empty || win == 2) msc = 0;
      else if (win == 1 && msc < SL) msc++;
    end
  endtask

  // Monitor: consumes the expected-write queue as strobes arrive.
  always @(posedge clk) begin
    wr_t w;
    #2;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      w = sb.pop_front();
      chk("missing_write_due", cyc, w.due);
    end
    if (wb_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_write", 1, 0);
      end else begin
        w = sb.pop_front();
        chk("wr_dst", wb_dst, w.dst);
        chk("wr_data", wb_data, w.data);
        chk("wr_cycle", cyc, w.due);
      end
    end else if (mvalid && wb_we !== 1'b0) begin
      chk("wb_we_known", 0, 1);
    end
  end

  initial begin
    // Reset, then a single pipeline write
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 4'd3, 8'h5A, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Two long-latency writes to r7 with the pipe idle
    step(0, 0, 0, 0, 1, 4'd7, 8'h11);
    step(0, 0, 0, 0, 1, 4'd7, 8'h22);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);
    // Pipe saturated while the FIFO fills: starvation guard and full-with-dequeue
    for (int i = 0; i < 14; i++)
      step(0, 1, PW'(i), DW'(8'h80 + i), 1, PW'(15 - i), DW'(8'hC0 + i));
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0);
    // Reset with queued entries and a write in flight
    for (int i = 0; i < 3; i++) step(0, 1, PW'(i + 1), DW'(8'h30 + i), 1, PW'(i + 8), DW'(8'h40 + i));
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);
    // Randomized phases: pipe-heavy, then mixed, with rare resets
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) == 0, (i < 300) ? ($urandom_range(0, 7) != 0) : $urandom_range(0, 1),
           PW'($urandom), DW'($urandom), $urandom_range(0, 2) != 0, PW'($urandom), DW'($urandom));
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    chk("fifo_drained", ll_pending, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Write-side producer for the core register file. Merges results from two sources onto the single RF write port (data, destination pointer, write flag):
  - the in-order execute pipeline;
  - the long-latency unit (memory/multiplier responses).
- Long-latency results are queued in a small FIFO.
- The pipeline has priority, but a starvation guard bounds how long the FIFO waits.

Parameters:
- DATA_W, 8, register width; matches the RF register range.
- PTR_W, 4, register pointer width; matches the RF pointer range.
- FIFO_DEPTH, 4, long-latency result FIFO entries; power of two, 2 or more.
- STARVE_LIMIT, 4, maximum consecutive pipeline grants while the FIFO is non-empty.

Ports:
- clk  in  1  core clock
- reset_WB  in  1  synchronous, active-high reset
- pipe_valid  in  1  execute result present
- pipe_dst  in  PTR_W  destination register of the execute result
- pipe_data  in  DATA_W  execute result
- pipe_ready  out  1  execute result accepted this cycle
- ll_valid  in  1  long-latency result present
- ll_dst  in  PTR_W  destination register of the long-latency result
- ll_data  in  DATA_W  long-latency result
- ll_ready  out  1  FIFO can take an entry
- wb_we  out  1  RF write flag, registered
- wb_dst  out  PTR_W  RF destination pointer, registered
- wb_data  out  DATA_W  RF write data, registered
- ll_pending  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (reset_WB=1 at posedge clk):
  - wb_we=0, wb_dst=0, wb_data=0.
  - FIFO emptied; ll_pending=0.
  - Starvation counter = 0.
  - A reset mid-operation discards all queued results. The RF is reset together with this block.
- ll_ready = (occupancy != FIFO_DEPTH), combinational.
  - An enqueue happens when ll_valid & ll_ready.
  - At full, ll_ready=0 even if a dequeue happens in the same cycle; no same-cycle pass-through of a full slot.
- Grant, evaluated each cycle:
  - starved = FIFO non-empty and starvation counter == STARVE_LIMIT.
  - If starved: FIFO head wins; pipe_ready=0.
  - Else if pipe_valid: pipeline wins; pipe_ready=1.
  - Else if FIFO non-empty: FIFO head wins.
  - Else: no write.
  - pipe_ready=1 whenever not starved, including when pipe_valid=0.
- Starvation counter:
  - Increments on each pipeline grant while the FIFO is non-empty, saturating at STARVE_LIMIT.
  - Clears on a FIFO grant, or whenever the FIFO is empty.
- Output register: the winner's dst/data load into wb_dst/wb_data and wb_we=1 on the next posedge. Latency is 1 cycle from grant to RF write strobe.
  - With no winner, wb_we=0 and wb_dst/wb_data hold their previous values.
- FIFO:
  - Circular buffer with read/write pointers wrapping mod FIFO_DEPTH.
  - Simultaneous enqueue and dequeue leaves occupancy unchanged.
  - Enqueue into an empty FIFO: the entry becomes eligible for grant on the following cycle, not the same cycle.
- Ordering and hazards:
  - FIFO entries retire in arrival order.
  - No ordering is guaranteed between the two sources. The hazard unit must not issue a younger pipeline write to a register with a pending long-latency write to the same register.
- Register 0 is not special here. The RF applies its own R0 init priority over a write-back.
- Back-to-back writes to the same dst in consecutive cycles are both emitted; the last one wins in the RF.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined:
  - Adds inputs fwd_src_0/1/2 (PTR_W each) and outputs fwd_hit_0/1/2 (1 bit) and fwd_data_0/1/2 (DATA_W).
  - fwd_hit_k = wb_we & (wb_dst == fwd_src_k); fwd_data_k = wb_data (combinational).
  - This lets decode bypass the RF write that is landing in the current cycle.
- Undefined: these ports and that logic are absent. Decode sees the written value one cycle later via the RF.

Test Plan:
- Reset, then pipe_valid=1, dst=3, data=0x5A for one cycle -> next cycle wb_we=1, wb_dst=3, wb_data=0x5A; the cycle after, wb_we=0.
- Only the long-latency source pushes dst=7 data=0x11, then dst=7 data=0x22 in consecutive cycles, with pipe idle -> writes emitted in that order, the first one 2 cycles after its push; ll_pending steps 1, 1, 0.
- Push 4 LL results with pipe_valid held at 1 -> ll_ready=0 at occupancy 4; after 4 pipeline grants, pipe_ready=0 for one cycle and the first LL result is written; the counter restarts.
- FIFO full, with a simultaneous dequeue and ll_valid=1 -> ll_ready stays 0 that cycle; the entry is accepted on the next cycle; no entry lost or duplicated.
- reset_WB asserted with 3 queued entries and wb_we=1 -> next cycle wb_we=0, ll_pending=0, ll_ready=1; no stale writes afterwards.
- With WB_FWD_EN, wb_we=1, wb_dst=5, fwd_src_1=5, fwd_src_0=4 -> fwd_hit_1=1, fwd_data_1=wb_data, fwd_hit_0=0.
